// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: bus widths, default base
// address and the 7-bit integrity function used on both write and read data.
package dmem_pkg;

  localparam int INTG_W = 7;
  localparam int BE_W   = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_2000;

  // Bit k of the result folds every data bit whose index is congruent to k mod 7.
  function automatic logic [INTG_W-1:0] calc_intg(input logic [31:0] data);
    logic [INTG_W-1:0] res;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      res[3'(i % INTG_W)] = res[3'(i % INTG_W)] ^ data[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_intg_gen.sv
// Combinational 32-bit to 7-bit integrity generator, shared by write-data
// checking and read-data integrity generation.
module intg_gen
  import dmem_pkg::*;
(
  input  logic [31:0]       data_i,
  output logic [INTG_W-1:0] intg_o
);

  assign intg_o = calc_intg(data_i);

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core's req/gnt/rvalid data bus: word-array storage
// with a programmable grant wait, byte-masked writes and integrity checking.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          GNT_WAIT    = 0,
  parameter bit          CHECK_INTG  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  input  logic [INTG_W-1:0] data_wdata_intg_i,
  output logic [31:0]       data_rdata_o,
  output logic [INTG_W-1:0] data_rdata_intg_o,
  output logic              data_err_o
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_CNT = 4'(GNT_WAIT);

  if (GNT_WAIT < 0 || GNT_WAIT > 15) begin : g_bad_gnt_wait
    $error("dmem_responder: GNT_WAIT must be in 0..15");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
  end

  logic [3:0]        cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [INTG_W-1:0] wdata_intg;
  logic              intg_ok;
  logic              wr_en;
  logic [31:0]       mem_q [DEPTH_WORDS];

  assign data_gnt_o = data_req_i && (cnt_q == WAIT_CNT) && !rst_i;

  // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both bounds.
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign idx      = offset[IDX_W+1:2];

  intg_gen u_wdata_intg (
    .data_i (data_wdata_i),
    .intg_o (wdata_intg)
  );

  assign intg_ok = !CHECK_INTG || (wdata_intg == data_wdata_intg_i);
  assign wr_en   = data_gnt_o && data_we_i && in_range && intg_ok;

  always_comb begin
    cnt_d = (!data_req_i || data_gnt_o) ? 4'd0 : cnt_q + 4'd1;
  end

  always_comb begin
    rvalid_d = data_gnt_o;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    if (data_gnt_o) begin
      rdata_d = '0;
      if (!in_range) begin
        err_d = 1'b1;
      end else if (data_we_i) begin
        err_d = !intg_ok;
      end else begin
        rdata_d = mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately left out of reset so committed writes survive it.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BE_W; b++) begin
      if (wr_en && data_be_i[b]) begin
        mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  intg_gen u_rdata_intg (
    .data_i (rdata_q),
    .intg_o (data_rdata_intg_o)
  );

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a zero-wait instance for the data path
// and a three-wait instance for grant timing.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req0, req3;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [6:0]  wintg;

  logic        gnt0, rv0, err0;
  logic [31:0] rd0;
  logic [6:0]  ri0;
  logic        gnt3, rv3, err3;
  logic [31:0] rd3;
  logic [6:0]  ri3;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.GNT_WAIT(0)) u_dut0 (
    .clk_i (clk), .rst_i (rst),
    .data_req_i (req0), .data_gnt_o (gnt0), .data_rvalid_o (rv0),
    .data_we_i (we), .data_be_i (be), .data_addr_i (addr),
    .data_wdata_i (wdata), .data_wdata_intg_i (wintg),
    .data_rdata_o (rd0), .data_rdata_intg_o (ri0), .data_err_o (err0)
  );

  dmem_responder #(.GNT_WAIT(3)) u_dut3 (
    .clk_i (clk), .rst_i (rst),
    .data_req_i (req3), .data_gnt_o (gnt3), .data_rvalid_o (rv3),
    .data_we_i (we), .data_be_i (be), .data_addr_i (addr),
    .data_wdata_i (wdata), .data_wdata_intg_i (wintg),
    .data_rdata_o (rd3), .data_rdata_intg_o (ri3), .data_err_o (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_intg(input logic [31:0] d);
    logic [6:0] r;
    r = '0;
    for (int k = 0; k < 7; k++)
      for (int i = k; i < 32; i += 7)
        r[k] = r[k] ^ d[i];
    return r;
  endfunction

  // One transaction on the zero-wait instance; samples gnt mid-cycle and the response after the edge.
  task automatic issue0(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [6:0] di,
                        output logic g, output logic v, output logic [31:0] r,
                        output logic [6:0] ri, output logic e);
    @(negedge clk);
    req0 = 1'b1; we = w; be = b; addr = a; wdata = d; wintg = di;
    #1 g = gnt0;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    v = rv0; r = rd0; ri = ri0; e = err0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req3 = 1'b0; we = 1'b0; be = 4'h0;
    addr = '0; wdata = '0; wintg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req0 = 1'b1;
    #1;
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt0); end
    checks++; if (rv0 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL reset_rvalid_err: got %b/%b want 0/0", rv0, err0); end
    checks++; if (rd0 !== 32'h0 || ri0 !== 7'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", rd0, ri0); end
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic g, v, e; logic [31:0] r; logic [6:0] ri;
    issue0(1'b1, 4'hF, 32'h2000, 32'hDEADBEEF, ref_intg(32'hDEADBEEF), g, v, r, ri, e);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", g); end
    checks++; if (v !== 1'b1 || e !== 1'b0 || r !== 32'h0) begin errors++; $display("FAIL wr_resp: got v=%b e=%b r=%h want 1 0 0", v, e, r); end
    issue0(1'b0, 4'h0, 32'h2000, 32'h0, 7'h0, g, v, r, ri, e);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", g); end
    checks++; if (v !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL rd_resp: got v=%b e=%b want 1 0", v, e); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", r); end
    checks++; if (ri !== ref_intg(32'hDEADBEEF)) begin errors++; $display("FAIL rd_intg: got %h want %h", ri, ref_intg(32'hDEADBEEF)); end
    @(posedge clk); #1;
    checks++; if (rv0 !== 1'b0 || err0 !== 1'b0 || rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got v=%b e=%b r=%h want 0 0 deadbeef", rv0, err0, rd0); end
  endtask

  task automatic test_byte_enable();
    logic g, v, e; logic [31:0] r; logic [6:0] ri;
    issue0(1'b1, 4'hF, 32'h2004, 32'h11223344, ref_intg(32'h11223344), g, v, r, ri, e);
    issue0(1'b1, 4'h1, 32'h2004, 32'h000000AA, ref_intg(32'h000000AA), g, v, r, ri, e);
    checks++; if (v !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL be_wr_resp: got v=%b e=%b want 1 0", v, e); end
    issue0(1'b0, 4'h0, 32'h2004, 32'h0, 7'h0, g, v, r, ri, e);
    checks++; if (r !== 32'h112233AA) begin errors++; $display("FAIL be_merge: got %h want 112233aa", r); end
    issue0(1'b1, 4'hA, 32'h2004, 32'h55667788, ref_intg(32'h55667788), g, v, r, ri, e);
    issue0(1'b0, 4'h0, 32'h2004, 32'h0, 7'h0, g, v, r, ri, e);
    checks++; if (r !== 32'h552277AA) begin errors++; $display("FAIL be_merge2: got %h want 552277aa", r); end
  endtask

  task automatic test_out_of_range();
    logic g, v, e; logic [31:0] r; logic [6:0] ri;
    issue0(1'b0, 4'hF, 32'h1FFC, 32'h0, 7'h0, g, v, r, ri, e);
    checks++; if (g !== 1'b1 || v !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL oor_rd: got g=%b v=%b e=%b r=%h want 1 1 1 0", g, v, e, r); end
    checks++; if (ri !== 7'h0) begin errors++; $display("FAIL oor_rd_intg: got %h want 0", ri); end
    issue0(1'b1, 4'hF, 32'h3000, 32'h55555555, ref_intg(32'h55555555), g, v, r, ri, e);
    checks++; if (v !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL oor_wr: got v=%b e=%b r=%h want 1 1 0", v, e, r); end
    @(posedge clk); #1;
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %b want 0", err0); end
    issue0(1'b0, 4'h0, 32'h2000, 32'h0, 7'h0, g, v, r, ri, e);
    checks++; if (r !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL oor_mem_intact: got %h e=%b want deadbeef 0", r, e); end
    issue0(1'b0, 4'h0, 32'h2FFC, 32'h0, 7'h0, g, v, r, ri, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL last_word_in_range: got e=%b want 0", e); end
  endtask

  task automatic test_intg_error();
    logic g, v, e; logic [31:0] r; logic [6:0] ri;
    issue0(1'b1, 4'hF, 32'h2008, 32'hCAFEF00D, ref_intg(32'hCAFEF00D), g, v, r, ri, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL intg_good_wr: got e=%b want 0", e); end
    issue0(1'b1, 4'hF, 32'h2008, 32'h12345678, ref_intg(32'h12345678) ^ 7'h01, g, v, r, ri, e);
    checks++; if (v !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL intg_bad_wr: got v=%b e=%b r=%h want 1 1 0", v, e, r); end
    issue0(1'b0, 4'h0, 32'h2008, 32'h0, 7'h0, g, v, r, ri, e);
    checks++; if (r !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL intg_mem_intact: got %h e=%b want cafef00d 0", r, e); end
  endtask

  task automatic test_raw_back_to_back();
    @(negedge clk);
    req0 = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h200C;
    wdata = 32'hA5A5_0F0F; wintg = ref_intg(32'hA5A5_0F0F);
    @(negedge clk);
    we = 1'b0; wdata = '0; wintg = '0;
    #1;
    checks++; if (gnt0 !== 1'b1 || rv0 !== 1'b1) begin errors++; $display("FAIL raw_overlap: got g=%b v=%b want 1 1", gnt0, rv0); end
    @(posedge clk); #1;
    req0 = 1'b0;
    checks++; if (rv0 !== 1'b1 || rd0 !== 32'hA5A5_0F0F) begin errors++; $display("FAIL raw_data: got v=%b r=%h want 1 a5a50f0f", rv0, rd0); end
  endtask

  task automatic test_back_to_back_reset();
    logic [31:0] a_tab [4];
    logic [31:0] d_tab [4];
    logic g, v, e; logic [31:0] r; logic [6:0] ri;
    a_tab[0] = 32'h2000; a_tab[1] = 32'h2004; a_tab[2] = 32'h2008; a_tab[3] = 32'h200C;
    d_tab[0] = 32'hDEADBEEF; d_tab[1] = 32'h552277AA; d_tab[2] = 32'hCAFEF00D; d_tab[3] = 32'hA5A5_0F0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0 = 1'b1; we = 1'b0; be = 4'h0; addr = a_tab[i];
      #1;
      checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d: got %b want 1", i, gnt0); end
      if (i > 0) begin
        checks++; if (rv0 !== 1'b1 || rd0 !== d_tab[i-1]) begin errors++; $display("FAIL b2b_rd%0d: got v=%b r=%h want 1 %h", i-1, rv0, rd0, d_tab[i-1]); end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1; req0 = 1'b0;
    #1;
    checks++; if (rv0 !== 1'b0 || err0 !== 1'b0 || gnt0 !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got v=%b e=%b g=%b want 0 0 0", rv0, err0, gnt0); end
    checks++; if (rd0 !== 32'h0 || ri0 !== 7'h0) begin errors++; $display("FAIL rst_mid_data: got %h/%h want 0/0", rd0, ri0); end
    @(posedge clk); #1;
    checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rvalid: got %b want 0", rv0); end
    @(negedge clk);
    rst = 1'b0;
    issue0(1'b0, 4'h0, 32'h2000, 32'h0, 7'h0, g, v, r, ri, e);
    checks++; if (r !== 32'hDEADBEEF || v !== 1'b1) begin errors++; $display("FAIL rst_mem_persist: got v=%b r=%h want 1 deadbeef", v, r); end
  endtask

  task automatic test_grant_wait();
    logic [3:0] gseen;
    @(negedge clk);
    req3 = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h1000;
    for (int c = 0; c < 4; c++) begin
      #1 gseen[c] = gnt3;
      if (c < 3) @(negedge clk);
    end
    checks++; if (gseen !== 4'b1000) begin errors++; $display("FAIL wait3_gnt_cycle: got %b want 1000", gseen); end
    @(posedge clk); #1;
    req3 = 1'b0;
    checks++; if (rv3 !== 1'b1 || err3 !== 1'b1) begin errors++; $display("FAIL wait3_rvalid: got v=%b e=%b want 1 1", rv3, err3); end
    @(posedge clk); #1;
    checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL wait3_single_rvalid: got %b want 0", rv3); end
    // Abandoned request: two cycles of req, then drop.
    @(negedge clk);
    req3 = 1'b1;
    #1 gseen[0] = gnt3;
    @(negedge clk);
    #1 gseen[1] = gnt3;
    req3 = 1'b0;
    gseen[2] = 1'b0; gseen[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      gseen[2] = gseen[2] | rv3;
    end
    checks++; if (gseen[1:0] !== 2'b00) begin errors++; $display("FAIL abort_gnt: got %b want 00", gseen[1:0]); end
    checks++; if (gseen[2] !== 1'b0) begin errors++; $display("FAIL abort_rvalid: got %b want 0", gseen[2]); end
    // Counter must have cleared: a fresh request again waits the full three cycles.
    @(negedge clk);
    req3 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 gseen[c] = gnt3;
      if (c < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    req3 = 1'b0;
    checks++; if (gseen !== 4'b1000) begin errors++; $display("FAIL abort_counter_clear: got %b want 1000", gseen); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_intg_error();
    test_raw_back_to_back();
    test_back_to_back_reset();
    test_grant_wait();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
